// File: rtl/nvdla_dbb_axi_mem_slave.sv
// nvdla_dbb_axi_mem_slave
// AXI responder for the NVDLA DBB master port. It serves INCR bursts of
// 64-bit beats from an internal register-array memory and stands in for the
// external DDR path in simulation and FPGA bring-up. The write and read
// channels are independent and may run at the same time.
//
// Ports:
//   core_clk, rstn          : single clock; synchronous active-low reset
//   nvdla_core2dbb_aw_*     : write address (id, len = beats-1, byte address)
//   nvdla_core2dbb_w_*      : write data, byte strobes, last flag (ignored)
//   nvdla_core2dbb_b_*      : write response id; m_axi_bresp carries the code
//   nvdla_core2dbb_ar_*     : read address (id, len = beats-1, byte address)
//   nvdla_core2dbb_r_*      : read data, id, last flag; m_axi_rresp carries the code
//
// Configuration macro: NVDLA_DBB_MEM_RANGE_CHECK_EN
//   undefined : addresses wrap modulo the memory depth, responses are OKAY
//   defined   : bursts that leave the window are answered with SLVERR, write
//               data is dropped and read data is zero
module nvdla_dbb_axi_mem_slave #(
   parameter int          MEM_AW    = 12,
   parameter logic [63:0] BASE_ADDR = 64'h0
) (
   input  logic        core_clk,
   input  logic        rstn,
   input  logic        nvdla_core2dbb_aw_awvalid,
   output logic        nvdla_core2dbb_aw_awready,
   input  logic [7:0]  nvdla_core2dbb_aw_awid,
   input  logic [3:0]  nvdla_core2dbb_aw_awlen,
   input  logic [63:0] nvdla_core2dbb_aw_awaddr,
   input  logic        nvdla_core2dbb_w_wvalid,
   output logic        nvdla_core2dbb_w_wready,
   input  logic [63:0] nvdla_core2dbb_w_wdata,
   input  logic [7:0]  nvdla_core2dbb_w_wstrb,
   input  logic        nvdla_core2dbb_w_wlast,
   output logic        nvdla_core2dbb_b_bvalid,
   input  logic        nvdla_core2dbb_b_bready,
   output logic [7:0]  nvdla_core2dbb_b_bid,
   output logic [1:0]  m_axi_bresp,
   input  logic        nvdla_core2dbb_ar_arvalid,
   output logic        nvdla_core2dbb_ar_arready,
   input  logic [7:0]  nvdla_core2dbb_ar_arid,
   input  logic [3:0]  nvdla_core2dbb_ar_arlen,
   input  logic [63:0] nvdla_core2dbb_ar_araddr,
   output logic        nvdla_core2dbb_r_rvalid,
   input  logic        nvdla_core2dbb_r_rready,
   output logic [7:0]  nvdla_core2dbb_r_rid,
   output logic        nvdla_core2dbb_r_rlast,
   output logic [63:0] nvdla_core2dbb_r_rdata,
   output logic [1:0]  m_axi_rresp
);

   localparam int DEPTH = 1 << MEM_AW;

   localparam logic [1:0] W_IDLE = 2'd0;
   localparam logic [1:0] W_DATA = 2'd1;
   localparam logic [1:0] W_RESP = 2'd2;
   localparam logic [0:0] R_IDLE = 1'b0;
   localparam logic [0:0] R_DATA = 1'b1;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;

   // Word index of a byte address; the truncating cast gives the modulo-depth wrap.
   function automatic logic [MEM_AW-1:0] word_idx(input logic [63:0] addr);
      return MEM_AW'((addr - BASE_ADDR) >> 3);
   endfunction

`ifdef NVDLA_DBB_MEM_RANGE_CHECK_EN
   // A burst is out of range if it starts below the window or its last beat
   // reaches past it. 65-bit arithmetic keeps the end address from overflowing.
   function automatic logic burst_oor(input logic [63:0] addr, input logic [3:0] len);
      logic [64:0] last_addr;
      last_addr = {1'b0, addr} + {58'd0, len, 3'b000};
      return (addr < BASE_ADDR) ||
             (last_addr >= ({1'b0, BASE_ADDR} + (65'd8 << MEM_AW)));
   endfunction
`endif

   logic [63:0] mem [0:DEPTH-1];

   logic              aw_oor_s, ar_oor_s, mem_we_s;
   logic [1:0]        w_state_q, w_state_d, bresp_q, bresp_d;
   logic [7:0]        w_id_q, w_id_d;
   logic [3:0]        w_len_q, w_len_d, w_cnt_q, w_cnt_d;
   logic [MEM_AW-1:0] w_idx_q, w_idx_d;
   logic              w_err_q, w_err_d, awready_q, awready_d;
   logic              wready_q, wready_d, bvalid_q, bvalid_d;

   logic [0:0]        r_state_q, r_state_d;
   logic [7:0]        rid_q, rid_d;
   logic [3:0]        r_len_q, r_len_d, r_cnt_q, r_cnt_d;
   logic [MEM_AW-1:0] r_idx_q, r_idx_d;
   logic              r_err_q, r_err_d, arready_q, arready_d;
   logic              rvalid_q, rvalid_d, rlast_q, rlast_d;
   logic [63:0]       rdata_q, rdata_d;
   logic [1:0]        rresp_q, rresp_d;

`ifdef NVDLA_DBB_MEM_RANGE_CHECK_EN
   assign aw_oor_s = burst_oor(nvdla_core2dbb_aw_awaddr, nvdla_core2dbb_aw_awlen);
   assign ar_oor_s = burst_oor(nvdla_core2dbb_ar_araddr, nvdla_core2dbb_ar_arlen);
`else
   assign aw_oor_s = 1'b0;
   assign ar_oor_s = 1'b0;
`endif

   // Write FSM: address latch, beat-counted data phase, response hold.
   always_comb begin
      w_state_d = w_state_q;
      w_id_d    = w_id_q;
      w_len_d   = w_len_q;
      w_cnt_d   = w_cnt_q;
      w_idx_d   = w_idx_q;
      w_err_d   = w_err_q;
      bresp_d   = bresp_q;
      mem_we_s  = 1'b0;
      case (w_state_q)
         W_IDLE: begin
            if (nvdla_core2dbb_aw_awvalid && awready_q) begin
               w_id_d    = nvdla_core2dbb_aw_awid;
               w_len_d   = nvdla_core2dbb_aw_awlen;
               w_idx_d   = word_idx(nvdla_core2dbb_aw_awaddr);
               w_cnt_d   = 4'd0;
               w_err_d   = aw_oor_s;
               w_state_d = W_DATA;
            end else begin
               w_state_d = W_IDLE;
            end
         end
         W_DATA: begin
            if (nvdla_core2dbb_w_wvalid && wready_q) begin
               // Out-of-range beats are accepted but never reach the array.
               mem_we_s = !w_err_q;
               w_idx_d  = w_idx_q + 1'b1;
               w_cnt_d  = w_cnt_q + 4'd1;
               // The burst ends on the beat count alone; wlast plays no part.
               if (w_cnt_q == w_len_q) begin
                  w_state_d = W_RESP;
                  bresp_d   = w_err_q ? RESP_SLVERR : RESP_OKAY;
               end else begin
                  w_state_d = W_DATA;
               end
            end else begin
               w_state_d = W_DATA;
            end
         end
         W_RESP: begin
            if (bvalid_q && nvdla_core2dbb_b_bready) begin
               w_state_d = W_IDLE;
            end else begin
               w_state_d = W_RESP;
            end
         end
         default: begin
            w_state_d = W_IDLE;
         end
      endcase
      awready_d = (w_state_d == W_IDLE);
      wready_d  = (w_state_d == W_DATA);
      bvalid_d  = (w_state_d == W_RESP);
   end

   // Read FSM: the array is read combinationally so the registered rdata holds
   // pre-edge contents, which gives old data on a same-edge write collision.
   always_comb begin
      r_state_d = r_state_q;
      rid_d     = rid_q;
      r_len_d   = r_len_q;
      r_cnt_d   = r_cnt_q;
      r_idx_d   = r_idx_q;
      r_err_d   = r_err_q;
      rlast_d   = rlast_q;
      rdata_d   = rdata_q;
      rresp_d   = rresp_q;
      case (r_state_q)
         R_IDLE: begin
            if (nvdla_core2dbb_ar_arvalid && arready_q) begin
               r_idx_d   = word_idx(nvdla_core2dbb_ar_araddr);
               rid_d     = nvdla_core2dbb_ar_arid;
               r_len_d   = nvdla_core2dbb_ar_arlen;
               r_cnt_d   = 4'd0;
               r_err_d   = ar_oor_s;
               rdata_d   = ar_oor_s ? 64'd0 : mem[r_idx_d];
               rresp_d   = ar_oor_s ? RESP_SLVERR : RESP_OKAY;
               rlast_d   = (nvdla_core2dbb_ar_arlen == 4'd0);
               r_state_d = R_DATA;
            end else begin
               r_state_d = R_IDLE;
            end
         end
         R_DATA: begin
            if (rvalid_q && nvdla_core2dbb_r_rready) begin
               if (rlast_q) begin
                  rlast_d   = 1'b0;
                  r_state_d = R_IDLE;
               end else begin
                  r_idx_d   = r_idx_q + 1'b1;
                  r_cnt_d   = r_cnt_q + 4'd1;
                  rdata_d   = r_err_q ? 64'd0 : mem[r_idx_d];
                  rlast_d   = (r_cnt_d == r_len_q);
                  r_state_d = R_DATA;
               end
            end else begin
               r_state_d = R_DATA;
            end
         end
         default: begin
            r_state_d = R_IDLE;
         end
      endcase
      arready_d = (r_state_d == R_IDLE);
      rvalid_d  = (r_state_d == R_DATA);
   end

   // Channel state and registered outputs with synchronous reset.
   always_ff @(posedge core_clk) begin
      if (!rstn) begin
         w_state_q <= W_IDLE;
         w_id_q    <= 8'd0;
         w_len_q   <= 4'd0;
         w_cnt_q   <= 4'd0;
         w_idx_q   <= '0;
         w_err_q   <= 1'b0;
         bresp_q   <= RESP_OKAY;
         awready_q <= 1'b1;
         wready_q  <= 1'b0;
         bvalid_q  <= 1'b0;
         r_state_q <= R_IDLE;
         rid_q     <= 8'd0;
         r_len_q   <= 4'd0;
         r_cnt_q   <= 4'd0;
         r_idx_q   <= '0;
         r_err_q   <= 1'b0;
         rlast_q   <= 1'b0;
         rdata_q   <= 64'd0;
         rresp_q   <= RESP_OKAY;
         arready_q <= 1'b1;
         rvalid_q  <= 1'b0;
      end else begin
         w_state_q <= w_state_d;
         w_id_q    <= w_id_d;
         w_len_q   <= w_len_d;
         w_cnt_q   <= w_cnt_d;
         w_idx_q   <= w_idx_d;
         w_err_q   <= w_err_d;
         bresp_q   <= bresp_d;
         awready_q <= awready_d;
         wready_q  <= wready_d;
         bvalid_q  <= bvalid_d;
         r_state_q <= r_state_d;
         rid_q     <= rid_d;
         r_len_q   <= r_len_d;
         r_cnt_q   <= r_cnt_d;
         r_idx_q   <= r_idx_d;
         r_err_q   <= r_err_d;
         rlast_q   <= rlast_d;
         rdata_q   <= rdata_d;
         rresp_q   <= rresp_d;
         arready_q <= arready_d;
         rvalid_q  <= rvalid_d;
      end
   end

   // Byte-masked memory write; contents survive reset, but a beat on a reset edge is dropped.
   always_ff @(posedge core_clk) begin
      if (rstn && mem_we_s) begin
         for (int i = 0; i < 8; i++) begin
            if (nvdla_core2dbb_w_wstrb[i]) begin
               mem[w_idx_q][8*i +: 8] <= nvdla_core2dbb_w_wdata[8*i +: 8];
            end
         end
      end
   end

   assign nvdla_core2dbb_aw_awready = awready_q;
   assign nvdla_core2dbb_w_wready   = wready_q;
   assign nvdla_core2dbb_b_bvalid   = bvalid_q;
   assign nvdla_core2dbb_b_bid      = w_id_q;
   assign m_axi_bresp               = bresp_q;
   assign nvdla_core2dbb_ar_arready = arready_q;
   assign nvdla_core2dbb_r_rvalid   = rvalid_q;
   assign nvdla_core2dbb_r_rid      = rid_q;
   assign nvdla_core2dbb_r_rlast    = rlast_q;
   assign nvdla_core2dbb_r_rdata    = rdata_q;
   assign m_axi_rresp               = rresp_q;

endmodule
